// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter
// Arbitrates NPORT read requesters onto a single AXI3 AR/R channel pair,
// one burst outstanding at a time. A per-port flush drops the owner's
// remaining beats while the AXI burst still drains to completion.
// Optional build macro: AXI_RD_ROUND_ROBIN_EN selects round-robin
// arbitration; without it the lowest requesting index wins.
module axi_read_arbiter #(
    parameter int NPORT = 2,
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int ID_W  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NPORT-1:0]   req_valid,
    input  logic [NPORT*AW-1:0] req_addr,
    input  logic [NPORT*4-1:0] req_len,
    output logic [NPORT-1:0]   req_ready,
    input  logic [NPORT-1:0]   flush,
    output logic [NPORT-1:0]   resp_valid,
    output logic [DW-1:0]      resp_data,
    output logic               resp_last,
    output logic [ID_W-1:0]    arid,
    output logic [AW-1:0]      araddr,
    output logic [3:0]         arlen,
    output logic [2:0]         arsize,
    output logic [1:0]         arburst,
    output logic [1:0]         arlock,
    output logic [3:0]         arcache,
    output logic [2:0]         arprot,
    output logic               arvalid,
    input  logic               arready,
    input  logic [ID_W-1:0]    rid,
    input  logic [DW-1:0]      rdata,
    input  logic [1:0]         rresp,
    input  logic               rlast,
    input  logic               rvalid,
    output logic               rready
);

    localparam int         GW   = (NPORT > 1) ? $clog2(NPORT) : 1;
    localparam logic [2:0] SIZE = (DW == 64) ? 3'b011 : 3'b010;

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t        state, state_nxt;
    logic [GW-1:0] g_q;
    logic [AW-1:0] addr_q;
    logic [3:0]    len_q;
    logic          drop;
    logic [GW-1:0] win;
    logic          win_vld;
    logic          grant;
    logic [GW-1:0] start;

    // rid/rresp carry nothing we act on; one burst in flight means no reordering.
    logic unused_ok;
    assign unused_ok = ^{rid, rresp};

    function automatic int wrap(input int s, input int i);
        return (s + i >= NPORT) ? s + i - NPORT : s + i;
    endfunction

`ifdef AXI_RD_ROUND_ROBIN_EN
    // ptr holds the index where the next search starts (last grant + 1).
    logic [GW-1:0] ptr;

    // Advance the search start past each winner, only when a grant happens.
    always_ff @(posedge clk) begin
        if (rst)
            ptr <= '0;
        else if (grant)
            ptr <= (int'(win) + 1 == NPORT) ? '0 : win + 1'b1;
    end

    assign start = ptr;
`else
    assign start = '0;
`endif

    // Pick the first requesting port scanning upward from the start index.
    always_comb begin
        win_vld = 1'b0;
        win     = '0;
        for (int i = 0; i < NPORT; i++) begin
            if (!win_vld && req_valid[wrap(int'(start), i)]) begin
                win_vld = 1'b1;
                win     = GW'(wrap(int'(start), i));
            end
        end
    end

    // No acceptance during the reset cycle: the latch would be discarded.
    assign grant = (state == IDLE) && win_vld && !rst;

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (win_vld)          state_nxt = ADDR;
            ADDR: if (arready)          state_nxt = DATA;
            DATA: if (rvalid && rlast)  state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    // Capture the winner's request; flush from the owner marks the burst dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            g_q    <= '0;
            addr_q <= '0;
            len_q  <= '0;
            drop   <= 1'b0;
        end else if (grant) begin
            g_q    <= win;
            addr_q <= req_addr[win*AW +: AW];
            len_q  <= req_len[win*4 +: 4];
            drop   <= 1'b0;
        end else if (state != IDLE && flush[g_q]) begin
            drop   <= 1'b1;
        end
    end

    assign araddr  = addr_q;
    assign arlen   = len_q;
    assign arid    = ID_W'(g_q);
    assign arlock  = 2'b00;
    assign arcache = 4'b0000;
    assign arprot  = 3'b000;

    // Output decode; R beats pass straight through, masked when dropped.
    always_comb begin
        req_ready  = '0;
        resp_valid = '0;
        resp_data  = '0;
        resp_last  = 1'b0;
        arvalid    = 1'b0;
        arsize     = 3'b000;
        arburst    = 2'b00;
        rready     = 1'b0;
        unique case (state)
            IDLE: if (grant) req_ready[win] = 1'b1;
            ADDR: begin
                arvalid = 1'b1;
                arsize  = SIZE;
                arburst = 2'b01;
            end
            DATA: begin
                rready = 1'b1;
                if (rvalid) begin
                    resp_valid[g_q] = ~(drop | flush[g_q]);
                    resp_data       = rdata;
                    resp_last       = rlast;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb_axi_read_arbiter
// Directed and randomized bursts against a spec-level model of grant order,
// AR field values and beat delivery/suppression.
module tb_axi_read_arbiter;

    localparam int NPORT = 2;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int ID_W  = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NPORT-1:0]    req_valid = '0;
    logic [NPORT*AW-1:0] req_addr = '0;
    logic [NPORT*4-1:0]  req_len = '0;
    logic [NPORT-1:0]    req_ready;
    logic [NPORT-1:0]    flush = '0;
    logic [NPORT-1:0]    resp_valid;
    logic [DW-1:0]       resp_data;
    logic                resp_last;
    logic [ID_W-1:0]     arid;
    logic [AW-1:0]       araddr;
    logic [3:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic [1:0]          arlock;
    logic [3:0]          arcache;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready = 1'b0;
    logic [ID_W-1:0]     rid = '0;
    logic [DW-1:0]       rdata = '0;
    logic [1:0]          rresp = '0;
    logic                rlast = 1'b0;
    logic                rvalid = 1'b0;
    logic                rready;

    axi_read_arbiter #(.NPORT(NPORT), .AW(AW), .DW(DW), .ID_W(ID_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len),
        .req_ready(req_ready), .flush(flush),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_last(resp_last),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int rr_next = 0;                 // model: next port to search from
    logic [NPORT-1:0] obs_rr[$];     // observed req_ready at each grant
    logic [1:0] exp_seq [4];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Model of the arbitration rule.
    function automatic int pick(input logic [NPORT-1:0] r);
`ifdef AXI_RD_ROUND_ROBIN_EN
        for (int k = 0; k < NPORT; k++)
            if (r[(rr_next + k) % NPORT]) return (rr_next + k) % NPORT;
`else
        for (int k = 0; k < NPORT; k++)
            if (r[k]) return k;
`endif
        return -1;
    endfunction

    task automatic chk_zero(input string tag);
        #1;
        chk({tag, "_req_ready"}, req_ready, 0);
        chk({tag, "_resp_valid"}, resp_valid, 0);
        chk({tag, "_resp_data"}, resp_data, 0);
        chk({tag, "_resp_last"}, resp_last, 0);
        chk({tag, "_arvalid"}, arvalid, 0);
        chk({tag, "_rready"}, rready, 0);
        chk({tag, "_ar_fields"}, {arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot}, 0);
    endtask

    // One full transaction starting in an IDLE cycle. fl_beat: -1 flush in
    // ADDR, 0..len flush on that beat, anything larger means no flush.
    task automatic txn(input logic [NPORT-1:0] reqs, input int ar_wait,
                       input int gap, input int fl_beat);
        int g;
        logic [NPORT-1:0] oh;
        logic [AW-1:0] a;
        logic [3:0] l;
        logic [DW-1:0] d;
        logic dropped;
        req_valid = reqs;
        flush = NPORT'($urandom);   // flush while idle must be ignored
        #1;
        g = pick(reqs);
        oh = '0;
        oh[g] = 1'b1;
        chk("grant", req_ready, oh);
        obs_rr.push_back(req_ready);
        a = req_addr[g*AW +: AW];
        l = req_len[g*4 +: 4];
        rr_next = (g + 1) % NPORT;
        dropped = (fl_beat < 0);
        step;
        req_valid[g] = 1'b0;
        for (int c = 0; c <= ar_wait; c++) begin
            arready = (c == ar_wait);
            flush = ~oh & NPORT'($urandom);
            if (c == 0 && fl_beat < 0) flush[g] = 1'b1;
            #1;
            chk("arvalid", arvalid, 1);
            chk("araddr", araddr, a);
            chk("arlen", arlen, l);
            chk("arid", arid, g);
            chk("arsize_burst", {arsize, arburst}, {3'd2, 2'd1});
            chk("addr_hold", {req_ready, rready}, 0);
            step;
        end
        arready = 1'b0;
        for (int b = 0; b <= int'(l); b++) begin
            for (int z = 0; z < gap; z++) begin
                rvalid = 1'b0;
                flush = ~oh & NPORT'($urandom);
                #1;
                chk("gap", {rready, arvalid, resp_valid}, {1'b1, 1'b0, NPORT'(0)});
                step;
            end
            d = $urandom;
            rvalid = 1'b1;
            rdata = d;
            rlast = (b == int'(l));
            rid = ID_W'($urandom);
            rresp = 2'($urandom);
            flush = ~oh & NPORT'($urandom);
            if (b == fl_beat) begin
                flush[g] = 1'b1;
                dropped = 1'b1;
            end
            #1;
            chk("resp_valid", resp_valid, dropped ? 0 : oh);
            chk("resp_data", resp_data, d);
            chk("resp_last", resp_last, b == int'(l));
            chk("rready", rready, 1);
            step;
        end
        rvalid = 1'b0;
        rlast = 1'b0;
        flush = '0;
        #1;
        chk("idle_after", {rready, arvalid}, 0);
    endtask

    initial begin
        logic [NPORT-1:0] r;
        int fb;
        // Reset state.
        step;
        step;
        rst = 1'b0;
        chk_zero("reset");

        // Single beat from port 0.
        req_addr[0 +: AW] = 32'hBFC0_0000;
        req_len[0 +: 4] = 4'd0;
        txn(2'b01, 0, 0, 99);

        // Four-beat burst from port 1 with gapped R beats.
        req_addr[AW +: AW] = 32'h8000_1000;
        req_len[4 +: 4] = 4'd3;
        txn(2'b10, 0, 2, 99);

        // Contention from a fresh reset.
        rst = 1'b1;
        step;
        rst = 1'b0;
        rr_next = 0;
        obs_rr.delete();
        req_len = {4'd1, 4'd0};
        for (int k = 0; k < 4; k++) txn(2'b11, 0, 0, 99);
`ifdef AXI_RD_ROUND_ROBIN_EN
        exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
        exp_seq = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
        for (int k = 0; k < 4; k++) chk($sformatf("cont_grant%0d", k), obs_rr[k], exp_seq[k]);
        req_valid = '0;

        // Flush on beat 2 of a 4-beat burst, then arready held low 5 cycles,
        // then flush while the address is still pending.
        req_len[0 +: 4] = 4'd3;
        txn(2'b01, 0, 0, 1);
        txn(2'b01, 5, 0, 99);
        txn(2'b01, 1, 1, -1);

        // Reset while in DATA.
        req_valid = 2'b01;
        step;
        req_valid = '0;
        arready = 1'b1;
        step;
        arready = 1'b0;
        rvalid = 1'b1;
        rdata = 32'h1234_5678;
        step;
        rvalid = 1'b0;
        rst = 1'b1;
        step;
        rst = 1'b0;
        rr_next = 0;
        chk_zero("rst_data");
        req_len[0 +: 4] = 4'd2;
        txn(2'b01, 0, 0, 99);

        // Randomized traffic; held requests keep their address and length.
        for (int n = 0; n < 30; n++) begin
            for (int p = 0; p < NPORT; p++) begin
                if (!req_valid[p]) begin
                    req_addr[p*AW +: AW] = $urandom;
                    req_len[p*4 +: 4] = 4'($urandom_range(0, 5));
                end
            end
            r = req_valid | NPORT'($urandom);
            if (r == 0) r = 2'b01;
            case ($urandom_range(0, 3))
                0: fb = -1;
                1: fb = $urandom_range(0, 5);
                default: fb = 99;
            endcase
            txn(r, $urandom_range(0, 3), $urandom_range(0, 2), fb);
        end
        req_valid = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
